// File: rtl/clock_digit_counter.sv
// MM:SS BCD time counter with 1 Hz prescaler, set-mode buttons and hour rollover pulse.
// Optional BUTTON_DEBOUNCE_EN: synchronise, debounce and edge-detect inc_sec/inc_min/clr.
module clock_digit_counter #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clr,
  input  logic       inc_sec,
  input  logic       inc_min,
  output logic [3:0] numcount1_out,
  output logic [3:0] numcount2_out,
  output logic [3:0] numcount3_out,
  output logic [3:0] numcount4_out,
  output logic       tick,
  output logic       hour_pulse
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || DEBOUNCE_CYC == 0) begin : g_param_guard
    $error("clock_digit_counter: TICK_DIV must be >= 2 and DEBOUNCE_CYC >= 1");
  end

  logic clr_e, inc_sec_e, inc_min_e;

`ifdef BUTTON_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q, stable_q, prev_q;
  logic [DW-1:0] cnt_q [3];

  assign raw = {clr, inc_min, inc_sec};

  // A new level is accepted only after DEBOUNCE_CYC consecutive cycles differing from the held one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= stable_q;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (cnt_q[i] == DB_LAST) begin
            stable_q[i] <= sync2_q[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign {clr_e, inc_min_e, inc_sec_e} = stable_q & ~prev_q;
`else
  assign clr_e     = clr;
  assign inc_sec_e = inc_sec;
  assign inc_min_e = inc_min;
`endif

  // Returns {carry, tens, units} of a BCD mod-60 increment.
  function automatic logic [8:0] inc60(input logic [7:0] bcd);
    logic [3:0] t, u;
    logic       c;
    t = bcd[7:4];
    u = bcd[3:0];
    c = 1'b0;
    if (u >= 4'd9) begin
      u = 4'd0;
      if (t >= 4'd5) begin
        t = 4'd0;
        c = 1'b1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {c, t, u};
  endfunction

  logic [7:0]    sec_q, sec_d, min_q, min_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d, hour_q, hour_d;
  logic [8:0]    sec_inc, min_inc;

  always_comb begin
    sec_inc = inc60(sec_q);
    min_inc = inc60(min_q);
  end

  // Digits advance on the cycle where the registered tick is high, so they lag the tick by one cycle.
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    pre_d  = pre_q;
    tick_d = 1'b0;
    hour_d = 1'b0;
    if (clr_e) begin
      sec_d = '0;
      min_d = '0;
      pre_d = '0;
    end else begin
      if (run) begin
        if (pre_q == PRE_LAST) begin
          pre_d  = '0;
          tick_d = 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      if (tick_q) begin
        sec_d = sec_inc[7:0];
        if (sec_inc[8]) begin
          min_d  = min_inc[7:0];
          hour_d = min_inc[8];
        end
      end else if (!run) begin
        if (inc_sec_e) sec_d = sec_inc[7:0];
        if (inc_min_e) min_d = min_inc[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q  <= '0;
      min_q  <= '0;
      pre_q  <= '0;
      tick_q <= 1'b0;
      hour_q <= 1'b0;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      pre_q  <= pre_d;
      tick_q <= tick_d;
      hour_q <= hour_d;
    end
  end

  assign numcount1_out = sec_q[3:0];
  assign numcount2_out = sec_q[7:4];
  assign numcount3_out = min_q[3:0];
  assign numcount4_out = min_q[7:4];
  assign tick          = tick_q;
  assign hour_pulse    = hour_q;

endmodule

// File: tb/tb_clock_digit_counter.sv
// Directed self-checking bench for clock_digit_counter (TICK_DIV=4, DEBOUNCE_CYC=3).
module tb_clock_digit_counter;

  logic       clk = 1'b0;
  logic       rst_n, run, clr, inc_sec, inc_min;
  logic [3:0] n1, n2, n3, n4;
  logic       tick, hour_pulse;
  logic [15:0] disp;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned tcount, hcount;

  clock_digit_counter #(.TICK_DIV(4), .DEBOUNCE_CYC(3)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clr(clr),
    .inc_sec(inc_sec), .inc_min(inc_min),
    .numcount1_out(n1), .numcount2_out(n2), .numcount3_out(n3), .numcount4_out(n4),
    .tick(tick), .hour_pulse(hour_pulse)
  );

  always #5 clk = ~clk;
  assign disp = {n4, n3, n2, n1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 ns after each edge.
  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_time(input int unsigned m, input int unsigned s);
    clr = 1'b1; cyc(1); clr = 1'b0;
    inc_min = 1'b1; cyc(m); inc_min = 1'b0;
    inc_sec = 1'b1; cyc(s); inc_sec = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; clr = 1'b0; inc_sec = 1'b0; inc_min = 1'b0;
    #2;
    check("reset_disp", 32'(disp), 32'h0000);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_hour", 32'(hour_pulse), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

`ifndef BUTTON_DEBOUNCE_EN
    // Async reset in the middle of counting at 12:34
    set_time(12, 34);
    check("preload_1234", 32'(disp), 32'h1234);
    run = 1'b1;
    cyc(4);
    check("tick_before_rst", 32'(tick), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_disp", 32'(disp), 32'h0000);
    check("async_rst_tick", 32'(tick), 32'h0);
    check("async_rst_hour", 32'(hour_pulse), 32'h0);
    cyc(1);
    run = 1'b0;
    rst_n = 1'b1;
    cyc(1);
`endif

    // 40 running cycles give 10 ticks; last digit update lands one edge later
    tcount = 0;
    run = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (tick) tcount++;
    end
    run = 1'b0;
    cyc(1);
    check("run40_ticks", 32'(tcount), 32'd10);
    check("run40_disp", 32'(disp), 32'h0010);

`ifndef BUTTON_DEBOUNCE_EN
    // 59:58 -> 59:59 -> 00:00 with a single hour pulse
    set_time(59, 58);
    check("preload_5958", 32'(disp), 32'h5958);
    hcount = 0;
    run = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (hour_pulse) hcount++;
      if (i == 5) check("wrap_5959", 32'(disp), 32'h5959);
      if (i == 9) begin
        check("wrap_disp", 32'(disp), 32'h0000);
        check("wrap_hour", 32'(hour_pulse), 32'h1);
      end
    end
    run = 1'b0;
    check("hour_count", 32'(hcount), 32'd1);

    // Set mode wraps fields independently
    set_time(0, 59);
    check("preload_0059", 32'(disp), 32'h0059);
    inc_sec = 1'b1; cyc(1); inc_sec = 1'b0;
    check("inc_sec_wrap", 32'(disp), 32'h0000);
    check("inc_sec_nohour", 32'(hour_pulse), 32'h0);
    set_time(59, 7);
    inc_min = 1'b1; cyc(1); inc_min = 1'b0;
    check("inc_min_wrap", 32'(disp), 32'h0007);
    inc_min = 1'b1; inc_sec = 1'b1; cyc(1); inc_min = 1'b0; inc_sec = 1'b0;
    check("inc_both", 32'(disp), 32'h0108);

    // inc_sec ignored while running; clr on the prescaler terminal count suppresses the tick
    clr = 1'b1; cyc(1); clr = 1'b0;
    run = 1'b1;
    inc_sec = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      if (i == 3)  check("run_inc_ignored", 32'(disp), 32'h0000);
      if (i == 6)  check("run_one_tick", 32'(disp), 32'h0001);
      if (i == 10) check("run_two_ticks", 32'(disp), 32'h0002);
      if (i == 11) clr = 1'b1;
      if (i == 12) begin
        check("clr_disp", 32'(disp), 32'h0000);
        check("clr_no_tick", 32'(tick), 32'h0);
        clr = 1'b0;
      end
      if (i == 15) check("post_clr_no_tick", 32'(tick), 32'h0);
      if (i == 16) check("post_clr_tick", 32'(tick), 32'h1);
    end
    inc_sec = 1'b0;
    run = 1'b0;
    cyc(1);
`else
    // Short glitch rejected, long press gives exactly one minute step
    inc_min = 1'b1; cyc(2); inc_min = 1'b0;
    cyc(20);
    check("db_glitch", 32'(disp), 32'h0010);
    inc_min = 1'b1; cyc(10); inc_min = 1'b0;
    cyc(20);
    check("db_press", 32'(disp), 32'h0110);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
